hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Decode-stage hazard controller and the producer of the pipeline control consumed by the D->E pipeline register and the F->D register. Each cycle it compares the decode-stage source registers against in-flight destinations. It then drives `bubble_E`, wired to the D->E register's `stall` input so that register loads a NOP. It also drives the PC/F->D hold, the F->D flush for decode-resolved redirects, and operand-forwarding selects. A small load scoreboard supports multi-cycle load latency, and saturating counters record stall and flush activity.

## Interface
- `LOAD_LAT`, 1: number of bubbles needed between a load in E and a dependent instruction in D; legal range 1..4.
- `CNT_W`, 16: width of each performance counter.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rs1_D`, `rs2_D` in 5 each: decode-stage source registers.
- `use_rs1_D`, `use_rs2_D` in 1 each: the decode instruction reads that source.
- `valid_D` in 1: D holds a real instruction.
- `RW_E` in 5, `RegWrite_E` in 1, `MEMRd_E` in 1: E-stage destination register, write enable and load flag.
- `RW_M` in 5, `RegWrite_M` in 1: M-stage destination register and write enable.
- `RW_W` in 5, `RegWrite_W` in 1: WB-stage destination register and write enable.
- `redirect_D` in 1: D resolved a taken jump, taken branch or prediction correction.
- `stall_F` out 1: hold the PC.
- `stall_D` out 1: hold the F->D register.
- `bubble_E` out 1: insert a NOP into D->E.
- `flush_D` out 1: flush the F->D register.
- `fwdA_D`, `fwdB_D` out 2 each: forwarding select, 0 = register file, 1 = E, 2 = M, 3 = WB.
- `stall_cnt`, `flush_cnt` out `CNT_W` each: saturating event counters.
- `state` out 1: 0 = RUN, 1 = STALL.

## Operation
- **Load in E.** `ld_E` = `MEMRd_E & RegWrite_E & (RW_E != 0)`.
- **Scoreboard.**
  - The scoreboard is a shift register `sb[0..LOAD_LAT-1]` of {valid, rd}.
  - Each clock: `sb[0]` is set to {`ld_E`, `RW_E`} and `sb[i]` is set to `sb[i-1]`.
  - `sb[i]` holds a load of age i+1.
- **Source match.** A source matches when all of the following hold: its `use` bit is 1, the register is nonzero, and `valid_D` is 1.
- **Hazard.** `haz` = 1 when a matching source equals `RW_E` with `ld_E` = 1, or equals `sb[i].rd` with `sb[i].valid` = 1 for any i where i+1 < `LOAD_LAT`.
- **Stall outputs.** `stall_F` = `stall_D` = `bubble_E` = `haz`.
- **Flush.**
  - `flush_D` = `redirect_D & ~haz`.
  - A redirect whose instruction is stalled is not honoured. It is re-evaluated each cycle until the instruction issues.
- **Forwarding.** The first match, in priority order, sets the select; if none match, the select is 0.
  - 1 (E): E has `RegWrite_E`, `~MEMRd_E` and `RW_E` equal to the source.
  - 2 (M): M has `RegWrite_M` and `RW_M` equal to the source.
  - 3 (WB): WB has `RegWrite_W` and `RW_W` equal to the source.
  - Register 0 always selects 0.
- **FSM.**
  - RUN goes to STALL when `haz` = 1.
  - STALL stays in STALL while `haz` = 1.
  - STALL goes to RUN when `haz` = 0.
- **Counters.**
  - `stall_cnt` increments on every cycle with `haz` = 1.
  - `flush_cnt` increments on every cycle with `flush_D` = 1.
  - Both saturate at all-ones and never wrap.

## Timing
- `stall_*`, `bubble_E`, `flush_D` and `fwd*` are combinational from inputs and registered state, with zero latency.
- The scoreboard, FSM and counters are registered.
- **While `reset` = 0:**
  - Scoreboard valid bits are 0, `state` = RUN, and both counters are 0.
  - `stall_F`, `stall_D`, `bubble_E` and `flush_D` are forced to 0.
  - `fwdA_D` and `fwdB_D` are forced to 0.
- **Reset deassertion** takes effect at the first clock edge after `reset` rises.
- **Reset mid-stall** clears the scoreboard immediately. The stalled instruction proceeds once reset is released.
- **Load-use with `LOAD_LAT` = 1:** exactly one bubble. On the next cycle the load is in M, and the dependent instruction selects forward 2.
- **General `LOAD_LAT` = N:** exactly N consecutive bubbles. Because a bubble enters E, `ld_E` is 0 during the later cycles, and the scoreboard alone sustains the stall.
- **Two back-to-back loads**, the second independent: both are tracked. A dependent on the first stalls only for its remaining age.
- **`redirect_D` with `haz` in the same cycle:** `flush_D` = 0, no flush occurs and `flush_cnt` is unchanged.

## Structure
- The shared pipeline package holds:
  - the `fwd_sel_t` encodings FWD_RF, FWD_E, FWD_M and FWD_W;
  - the `hz_state_t` encodings RUN and STALL;
  - the constant REG_ZERO = 5'd0.
- One sub-module, `load_scoreboard`, contains the shift register and the age-qualified match logic. It is parameterized by `LOAD_LAT`, takes two source ports, and outputs a hit.
- Forwarding, FSM and counters stay in `hazard_ctrl`.

## Test plan
- **Load-use, `LOAD_LAT` = 1.** Load writes r5 (`MEMRd_E` = 1, `RegWrite_E` = 1, `RW_E` = 5); D uses `rs1_D` = 5.
  - Required: `bubble_E` = `stall_F` = `stall_D` = 1 for exactly 1 cycle.
  - On the next cycle `fwdA_D` = 2.
  - `stall_cnt` = 1.
- **`LOAD_LAT` = 3, dependent on r7.** Required: 3 consecutive stall cycles, then `fwdA_D` = 3 or 2 according to the stage holding r7 at that point, and `state` returns to RUN.
- **Register zero and unused sources.**
  - Load to r0, with a dependent reading r0: no stall.
  - `use_rs2_D` = 0 with `rs2_D` matching a load: no stall.
- **Forwarding priority.** `RW_E` = `RW_M` = `RW_W` = 9, all with write enable, no load, `rs2_D` = 9.
  - Required: `fwdB_D` = 1.
  - Clearing `RegWrite_E` gives `fwdB_D` = 2.
- **Redirect against stall.**
  - `redirect_D` = 1 during a load-use hazard: `flush_D` = 0.
  - On the next, hazard-free cycle: `flush_D` = 1 and `flush_cnt` increments by 1.
- **Reset and saturation.**
  - Assert `reset` = 0 mid-stall: outputs are 0 immediately.
  - With `CNT_W` = 4 and 20 stall cycles: `stall_cnt` holds at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline encodings for the decode-stage hazard controller.
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Youngest producer wins; a load in E cannot forward, so it is skipped.
  function automatic fwd_sel_t fwd_pick(
    input logic [4:0] src,
    input logic       we_e,
    input logic       rd_e,
    input logic [4:0] rw_e,
    input logic       we_m,
    input logic [4:0] rw_m,
    input logic       we_w,
    input logic [4:0] rw_w
  );
    if (src == REG_ZERO)                return FWD_RF;
    if (we_e && !rd_e && rw_e == src)   return FWD_E;
    if (we_m && rw_m == src)            return FWD_M;
    if (we_w && rw_w == src)            return FWD_W;
    return FWD_RF;
  endfunction
endpackage

// File: rtl/load_scoreboard.sv
// Tracks in-flight loads by age and flags decode sources that must still wait.
module load_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_E,
  input  logic [4:0] RW_E,
  input  logic       src1_vld,
  input  logic [4:0] src1,
  input  logic       src2_vld,
  input  logic [4:0] src2,
  output logic       hit
);
  logic [LOAD_LAT-1:0]      r_vld;
  logic [LOAD_LAT-1:0][4:0] r_rd;
  logic [LOAD_LAT-1:0]      w_age_hit;
  logic                     w_e_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      r_rd  <= '0;
    end else begin
      r_vld[0] <= ld_E;
      r_rd[0]  <= RW_E;
      for (int i = 1; i < LOAD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_rd[i]  <= r_rd[i-1];
      end
    end
  end

  // Entry g holds a load of age g+1; it only blocks while that age is short of LOAD_LAT.
  for (genvar g = 0; g < LOAD_LAT; g++) begin : g_age
    localparam bit AGE_OK = (g + 1 < LOAD_LAT);
    assign w_age_hit[g] = AGE_OK && r_vld[g] &&
                          ((src1_vld && src1 == r_rd[g]) || (src2_vld && src2 == r_rd[g]));
  end

  assign w_e_hit = ld_E && ((src1_vld && src1 == RW_E) || (src2_vld && src2 == RW_E));
  assign hit     = w_e_hit | (|w_age_hit);
endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: load-use stall, redirect flush, forwarding selects, event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             use_rs1_D,
  input  logic             use_rs2_D,
  input  logic             valid_D,
  input  logic [4:0]       RW_E,
  input  logic             RegWrite_E,
  input  logic             MEMRd_E,
  input  logic [4:0]       RW_M,
  input  logic             RegWrite_M,
  input  logic [4:0]       RW_W,
  input  logic             RegWrite_W,
  input  logic             redirect_D,
  output logic             stall_F,
  output logic             stall_D,
  output logic             bubble_E,
  output logic             flush_D,
  output logic [1:0]       fwdA_D,
  output logic [1:0]       fwdB_D,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             state
);
  logic       w_ld_E, w_m1, w_m2, w_hit, w_haz, w_flush;
  fwd_sel_t   w_fwdA, w_fwdB;
  hz_state_t  r_state, w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  assign w_ld_E = MEMRd_E & RegWrite_E & (RW_E != REG_ZERO);
  assign w_m1   = use_rs1_D & (rs1_D != REG_ZERO) & valid_D;
  assign w_m2   = use_rs2_D & (rs2_D != REG_ZERO) & valid_D;

  load_scoreboard #(.LOAD_LAT(LOAD_LAT)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .ld_E     (w_ld_E),
    .RW_E     (RW_E),
    .src1_vld (w_m1),
    .src1     (rs1_D),
    .src2_vld (w_m2),
    .src2     (rs2_D),
    .hit      (w_hit)
  );

  // Every control output is held quiet while reset is low.
  assign w_haz   = reset & w_hit;
  assign w_flush = reset & redirect_D & ~w_hit;

  assign stall_F  = w_haz;
  assign stall_D  = w_haz;
  assign bubble_E = w_haz;
  assign flush_D  = w_flush;

  assign w_fwdA = fwd_pick(rs1_D, RegWrite_E, MEMRd_E, RW_E, RegWrite_M, RW_M, RegWrite_W, RW_W);
  assign w_fwdB = fwd_pick(rs2_D, RegWrite_E, MEMRd_E, RW_E, RegWrite_M, RW_M, RegWrite_W, RW_W);
  assign fwdA_D = reset ? w_fwdA : FWD_RF;
  assign fwdB_D = reset ? w_fwdB : FWD_RF;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_haz)  w_state_nxt = STALL;
      STALL:   if (!w_haz) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_haz && r_stall_cnt != '1)   r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign state     = r_state;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=3, CNT_W=4) on shared stimulus.
module tb_hazard_ctrl;
  logic clk, reset;
  logic [4:0] rs1_D, rs2_D, RW_E, RW_M, RW_W;
  logic use_rs1_D, use_rs2_D, valid_D, RegWrite_E, MEMRd_E, RegWrite_M, RegWrite_W, redirect_D;

  logic        l1_sf, l1_sd, l1_bub, l1_fl, l1_st;
  logic [1:0]  l1_fa, l1_fb;
  logic [15:0] l1_sc, l1_fc;
  logic        l3_sf, l3_sd, l3_bub, l3_fl, l3_st;
  logic [1:0]  l3_fa, l3_fb;
  logic [15:0] l3_sc, l3_fc;
  logic        c4_sf, c4_sd, c4_bub, c4_fl, c4_st;
  logic [1:0]  c4_fa, c4_fb;
  logic [3:0]  c4_sc, c4_fc;

  int tests = 0;
  int fails = 0;

  hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u_l1 (
    .clk(clk), .reset(reset), .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D),
    .use_rs2_D(use_rs2_D), .valid_D(valid_D), .RW_E(RW_E), .RegWrite_E(RegWrite_E),
    .MEMRd_E(MEMRd_E), .RW_M(RW_M), .RegWrite_M(RegWrite_M), .RW_W(RW_W),
    .RegWrite_W(RegWrite_W), .redirect_D(redirect_D), .stall_F(l1_sf), .stall_D(l1_sd),
    .bubble_E(l1_bub), .flush_D(l1_fl), .fwdA_D(l1_fa), .fwdB_D(l1_fb),
    .stall_cnt(l1_sc), .flush_cnt(l1_fc), .state(l1_st));

  hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u_l3 (
    .clk(clk), .reset(reset), .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D),
    .use_rs2_D(use_rs2_D), .valid_D(valid_D), .RW_E(RW_E), .RegWrite_E(RegWrite_E),
    .MEMRd_E(MEMRd_E), .RW_M(RW_M), .RegWrite_M(RegWrite_M), .RW_W(RW_W),
    .RegWrite_W(RegWrite_W), .redirect_D(redirect_D), .stall_F(l3_sf), .stall_D(l3_sd),
    .bubble_E(l3_bub), .flush_D(l3_fl), .fwdA_D(l3_fa), .fwdB_D(l3_fb),
    .stall_cnt(l3_sc), .flush_cnt(l3_fc), .state(l3_st));

  hazard_ctrl #(.LOAD_LAT(1), .CNT_W(4)) u_c4 (
    .clk(clk), .reset(reset), .rs1_D(rs1_D), .rs2_D(rs2_D), .use_rs1_D(use_rs1_D),
    .use_rs2_D(use_rs2_D), .valid_D(valid_D), .RW_E(RW_E), .RegWrite_E(RegWrite_E),
    .MEMRd_E(MEMRd_E), .RW_M(RW_M), .RegWrite_M(RegWrite_M), .RW_W(RW_W),
    .RegWrite_W(RegWrite_W), .redirect_D(redirect_D), .stall_F(c4_sf), .stall_D(c4_sd),
    .bubble_E(c4_bub), .flush_D(c4_fl), .fwdA_D(c4_fa), .fwdB_D(c4_fb),
    .stall_cnt(c4_sc), .flush_cnt(c4_fc), .state(c4_st));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    rs1_D = 0; rs2_D = 0; use_rs1_D = 0; use_rs2_D = 0; valid_D = 0;
    RW_E = 0; RegWrite_E = 0; MEMRd_E = 0; RW_M = 0; RegWrite_M = 0;
    RW_W = 0; RegWrite_W = 0; redirect_D = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic load_e(input logic [4:0] rd);
    MEMRd_E = 1; RegWrite_E = 1; RW_E = rd;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 1'b0;
    valid_D = 1; use_rs1_D = 1; rs1_D = 5; load_e(5);
    RegWrite_M = 1; RW_M = 5; redirect_D = 1;
    #1;
    tests++; if ({l1_sf, l1_sd, l1_bub, l1_fl} !== 4'b0) begin fails++; $display("FAIL rst_ctrl got=%b exp=0000", {l1_sf, l1_sd, l1_bub, l1_fl}); end
    tests++; if (l1_fa !== 2'd0) begin fails++; $display("FAIL rst_fwdA got=%0d exp=0", l1_fa); end
    tick();
    tests++; if (l1_sc !== 16'd0 || l1_fc !== 16'd0) begin fails++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", l1_sc, l1_fc); end
    tests++; if (l1_st !== 1'b0) begin fails++; $display("FAIL rst_state got=%0b exp=0", l1_st); end
  endtask

  task automatic test_load_use;
    do_reset();
    valid_D = 1; use_rs1_D = 1; rs1_D = 5; load_e(5);
    #1;
    tests++; if ({l1_bub, l1_sf, l1_sd} !== 3'b111) begin fails++; $display("FAIL lu_stall got=%b exp=111", {l1_bub, l1_sf, l1_sd}); end
    tick();
    MEMRd_E = 0; RegWrite_E = 0; RW_E = 0; RegWrite_M = 1; RW_M = 5;
    #1;
    tests++; if (l1_bub !== 1'b0) begin fails++; $display("FAIL lu_release got=%0b exp=0", l1_bub); end
    tests++; if (l1_fa !== 2'd2) begin fails++; $display("FAIL lu_fwdA got=%0d exp=2", l1_fa); end
    tests++; if (l1_sc !== 16'd1) begin fails++; $display("FAIL lu_stall_cnt got=%0d exp=1", l1_sc); end
    tests++; if (l1_st !== 1'b1) begin fails++; $display("FAIL lu_state got=%0b exp=1", l1_st); end
    tick();
    tests++; if (l1_st !== 1'b0) begin fails++; $display("FAIL lu_state_run got=%0b exp=0", l1_st); end
  endtask

  task automatic test_lat3;
    int nstall;
    do_reset();
    nstall = 0;
    valid_D = 1; use_rs1_D = 1; rs1_D = 7; load_e(7);
    #1; if (l3_bub) nstall++;
    tick();
    MEMRd_E = 0; RegWrite_E = 0; RW_E = 0; RegWrite_M = 1; RW_M = 7;
    #1; if (l3_bub) nstall++;
    tests++; if (l1_bub !== 1'b0) begin fails++; $display("FAIL lat1_age1 got=%0b exp=0", l1_bub); end
    tick();
    RegWrite_M = 0; RW_M = 0; RegWrite_W = 1; RW_W = 7;
    #1; if (l3_bub) nstall++;
    tick();
    #1; if (l3_bub) nstall++;
    tests++; if (nstall != 3) begin fails++; $display("FAIL lat3_stalls got=%0d exp=3", nstall); end
    tests++; if (l3_bub !== 1'b0) begin fails++; $display("FAIL lat3_release got=%0b exp=0", l3_bub); end
    tests++; if (l3_fa !== 2'd3) begin fails++; $display("FAIL lat3_fwdA got=%0d exp=3", l3_fa); end
    tests++; if (l3_st !== 1'b1) begin fails++; $display("FAIL lat3_state_stall got=%0b exp=1", l3_st); end
    tick();
    tests++; if (l3_st !== 1'b0) begin fails++; $display("FAIL lat3_state_run got=%0b exp=0", l3_st); end
    tests++; if (l3_sc !== 16'd3) begin fails++; $display("FAIL lat3_stall_cnt got=%0d exp=3", l3_sc); end
  endtask

  task automatic test_zero_unused;
    do_reset();
    valid_D = 1; use_rs1_D = 1; rs1_D = 0; load_e(0); RegWrite_M = 1; RW_M = 0;
    #1;
    tests++; if (l3_bub !== 1'b0) begin fails++; $display("FAIL r0_stall got=%0b exp=0", l3_bub); end
    tests++; if (l3_fa !== 2'd0) begin fails++; $display("FAIL r0_fwdA got=%0d exp=0", l3_fa); end
    tick();
    MEMRd_E = 0; RegWrite_E = 0; RegWrite_M = 0;
    #1;
    tests++; if (l3_bub !== 1'b0) begin fails++; $display("FAIL r0_sb got=%0b exp=0", l3_bub); end
    use_rs1_D = 0; rs2_D = 6; use_rs2_D = 0; load_e(6);
    #1;
    tests++; if (l3_bub !== 1'b0) begin fails++; $display("FAIL unused_rs2 got=%0b exp=0", l3_bub); end
    use_rs2_D = 1; valid_D = 0;
    #1;
    tests++; if (l3_bub !== 1'b0) begin fails++; $display("FAIL invalid_D got=%0b exp=0", l3_bub); end
    valid_D = 1;
    #1;
    tests++; if (l3_bub !== 1'b1) begin fails++; $display("FAIL used_rs2 got=%0b exp=1", l3_bub); end
  endtask

  task automatic test_fwd_priority;
    do_reset();
    valid_D = 1; use_rs2_D = 1; rs2_D = 9;
    RegWrite_E = 1; RW_E = 9; RegWrite_M = 1; RW_M = 9; RegWrite_W = 1; RW_W = 9;
    #1;
    tests++; if (l1_fb !== 2'd1) begin fails++; $display("FAIL fwd_E got=%0d exp=1", l1_fb); end
    tests++; if (l1_bub !== 1'b0) begin fails++; $display("FAIL fwd_nostall got=%0b exp=0", l1_bub); end
    RegWrite_E = 0;
    #1;
    tests++; if (l1_fb !== 2'd2) begin fails++; $display("FAIL fwd_M got=%0d exp=2", l1_fb); end
    RegWrite_M = 0;
    #1;
    tests++; if (l1_fb !== 2'd3) begin fails++; $display("FAIL fwd_W got=%0d exp=3", l1_fb); end
    RegWrite_W = 0;
    #1;
    tests++; if (l1_fb !== 2'd0) begin fails++; $display("FAIL fwd_RF got=%0d exp=0", l1_fb); end
  endtask

  task automatic test_redirect;
    do_reset();
    valid_D = 1; use_rs1_D = 1; rs1_D = 5; load_e(5); redirect_D = 1;
    #1;
    tests++; if (l1_fl !== 1'b0) begin fails++; $display("FAIL redir_haz got=%0b exp=0", l1_fl); end
    tick();
    tests++; if (l1_fc !== 16'd0) begin fails++; $display("FAIL redir_cnt0 got=%0d exp=0", l1_fc); end
    MEMRd_E = 0; RegWrite_E = 0; RW_E = 0; RegWrite_M = 1; RW_M = 5;
    #1;
    tests++; if (l1_fl !== 1'b1) begin fails++; $display("FAIL redir_flush got=%0b exp=1", l1_fl); end
    tick();
    redirect_D = 0;
    #1;
    tests++; if (l1_fc !== 16'd1) begin fails++; $display("FAIL redir_cnt1 got=%0d exp=1", l1_fc); end
  endtask

  task automatic test_reset_mid_stall;
    do_reset();
    valid_D = 1; use_rs1_D = 1; rs1_D = 7; load_e(7);
    tick();
    MEMRd_E = 0; RegWrite_E = 0; RW_E = 0;
    #1;
    tests++; if (l3_bub !== 1'b1) begin fails++; $display("FAIL mid_pre got=%0b exp=1", l3_bub); end
    reset = 1'b0;
    #1;
    tests++; if ({l3_bub, l3_sf, l3_sd, l3_st} !== 4'b0) begin fails++; $display("FAIL mid_rst got=%b exp=0000", {l3_bub, l3_sf, l3_sd, l3_st}); end
    tests++; if (l3_sc !== 16'd0) begin fails++; $display("FAIL mid_rst_cnt got=%0d exp=0", l3_sc); end
    #1;
    reset = 1'b1;
    #1;
    tests++; if (l3_bub !== 1'b0) begin fails++; $display("FAIL mid_sb_clear got=%0b exp=0", l3_bub); end
    tick();
    tests++; if (l3_bub !== 1'b0 || l3_sc !== 16'd0) begin fails++; $display("FAIL mid_proceed got=%0b/%0d exp=0/0", l3_bub, l3_sc); end
  endtask

  task automatic test_saturation;
    do_reset();
    valid_D = 1; use_rs1_D = 1; rs1_D = 5; load_e(5);
    for (int k = 0; k < 15; k++) tick();
    tests++; if (c4_sc !== 4'd15) begin fails++; $display("FAIL sat_15 got=%0d exp=15", c4_sc); end
    for (int k = 0; k < 5; k++) tick();
    tests++; if (c4_sc !== 4'd15) begin fails++; $display("FAIL sat_hold got=%0d exp=15", c4_sc); end
    tests++; if (l1_sc !== 16'd20) begin fails++; $display("FAIL sat_wide got=%0d exp=20", l1_sc); end
    tests++; if (c4_bub !== 1'b1) begin fails++; $display("FAIL sat_bub got=%0b exp=1", c4_bub); end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_lat3();
    test_zero_unused();
    test_fwd_priority();
    test_redirect();
    test_reset_mid_stall();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
